// File: rtl/pay_settle.sv
// Keypad payment settlement: turns held paid codes into coin events, accumulates
// them against a latched price, then reports change (done) or refunds (refund).
module pay_settle #(
  parameter int AMT_W       = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] price,
  input  logic             cancel,
  input  logic [2:0]       paid,
  output logic             busy,
  output logic [AMT_W-1:0] paid_total,
  output logic [AMT_W-1:0] change,
  output logic             done,
  output logic             refund
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SETTLE  = 2'd2,
    REFUND  = 2'd3
  } state_t;

  state_t           state_r;
  logic [AMT_W-1:0] price_r;
  logic [2:0]       paid_q_r;
  logic [TW-1:0]    timer_r;

  logic             coin_evt_s;
  logic [AMT_W-1:0] new_total_s;
  logic             timeout_s;

  // Add a coin to the running total, clamping at the all-ones amount.
  function automatic logic [AMT_W-1:0] sat_add(input logic [AMT_W-1:0] a, input logic [2:0] b);
    logic [AMT_W:0] sum;
    sum = {1'b0, a} + {{(AMT_W - 2){1'b0}}, b};
    if (sum[AMT_W]) begin
      sat_add = {AMT_W{1'b1}};
    end else begin
      sat_add = sum[AMT_W-1:0];
    end
  endfunction

  // Coin edge detect, post-add total and timeout decision for the current cycle.
  always_comb begin
    coin_evt_s  = (paid != 3'd0) && (paid_q_r == 3'd0);
    new_total_s = paid_total;
    if (coin_evt_s) begin
      new_total_s = sat_add(paid_total, paid);
    end else begin
      new_total_s = paid_total;
    end
    // Fires when the incremented idle count would reach TIMEOUT_CYC-1.
    timeout_s = !coin_evt_s && (timer_r == TW'(TIMEOUT_CYC - 2));
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      price_r    <= {AMT_W{1'b0}};
      paid_q_r   <= 3'd0;
      timer_r    <= {TW{1'b0}};
      busy       <= 1'b0;
      paid_total <= {AMT_W{1'b0}};
      change     <= {AMT_W{1'b0}};
      done       <= 1'b0;
      refund     <= 1'b0;
    end else begin
      paid_q_r <= paid;
      done     <= 1'b0;
      refund   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && (price != {AMT_W{1'b0}})) begin
            price_r    <= price;
            paid_total <= {AMT_W{1'b0}};
            change     <= {AMT_W{1'b0}};
            timer_r    <= {TW{1'b0}};
            busy       <= 1'b1;
            state_r    <= COLLECT;
          end else begin
            state_r <= IDLE;
          end
        end
        COLLECT: begin
          paid_total <= new_total_s;
          if (coin_evt_s) begin
            timer_r <= {TW{1'b0}};
          end else begin
            timer_r <= timer_r + TW'(1);
          end
          // Payment outranks cancel; cancel outranks timeout.
          if (new_total_s >= price_r) begin
            state_r <= SETTLE;
          end else if (cancel || timeout_s) begin
            state_r <= REFUND;
          end else begin
            state_r <= COLLECT;
          end
        end
        SETTLE: begin
          change  <= paid_total - price_r;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        REFUND: begin
          change  <= paid_total;
          refund  <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pay_settle.sv
// Scoreboard bench for pay_settle: stimulus queues expected done/refund pulses,
// a negedge monitor pops and compares them as they appear.
module tb_pay_settle;

  localparam int AW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] price;
  logic          cancel;
  logic [2:0]    paid;
  logic          busy;
  logic [AW-1:0] paid_total;
  logic [AW-1:0] change;
  logic          done;
  logic          refund;

  pay_settle #(.AMT_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .price(price), .cancel(cancel),
    .paid(paid), .busy(busy), .paid_total(paid_total), .change(change),
    .done(done), .refund(refund)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            is_done;
    logic [AW-1:0] total;
    logic [AW-1:0] chg;
    int            at;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done/refund pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (done || refund)) begin
      chk("exclusive", {31'd0, done & refund}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%0d refund=%0d expected none (cycle %0d)", done, refund, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind_done", {31'd0, done}, {31'd0, e.is_done});
        chk("pulse_total", {24'd0, paid_total}, {24'd0, e.total});
        chk("pulse_change", {24'd0, change}, {24'd0, e.chg});
        chk("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_txn(input logic [AW-1:0] p);
    start = 1'b1;
    price = p;
    step(1);
    start = 1'b0;
    price = 8'd0;
    chk("busy_on", {31'd0, busy}, 32'd1);
  endtask

  // Drive one coin; optionally queue the pulse expected `lat` cycles after it.
  task automatic coin(input logic [2:0] v, input int hold, input int gap,
                      input bit expect_pulse, input bit is_done,
                      input logic [AW-1:0] tot, input logic [AW-1:0] chg, input int lat);
    paid = v;
    if (expect_pulse) q.push_back('{is_done: is_done, total: tot, chg: chg, at: cyc + lat});
    step(hold);
    paid = 3'd0;
    step(gap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; price = 8'd0; cancel = 1'b0; paid = 3'd0;
    step(2);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_total", {24'd0, paid_total}, 32'd0);
    rst_n = 1'b1;
    step(1);

    // Asynchronous reset in the middle of COLLECT.
    begin_txn(8'd50);
    coin(3'd3, 1, 1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    chk("mid_total", {24'd0, paid_total}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_total", {24'd0, paid_total}, 32'd0);
    chk("arst_change", {24'd0, change}, 32'd0);
    chk("arst_pulses", {30'd0, done, refund}, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    begin_txn(8'd4);
    coin(3'd4, 1, 3, 1'b1, 1'b1, 8'd4, 8'd0, 2);

    // price 10: coins 5, 3, 4 -> done change 2.
    begin_txn(8'd10);
    coin(3'd5, 3, 1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    chk("t2_total5", {24'd0, paid_total}, 32'd5);
    coin(3'd3, 3, 1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    chk("t2_total8", {24'd0, paid_total}, 32'd8);
    coin(3'd4, 3, 1, 1'b1, 1'b1, 8'd12, 8'd2, 2);
    chk("t2_busy_off", {31'd0, busy}, 32'd0);
    chk("t2_total_held", {24'd0, paid_total}, 32'd12);

    // price 6, 7 held 20 cycles -> exactly one event.
    begin_txn(8'd6);
    coin(3'd7, 20, 1, 1'b1, 1'b1, 8'd7, 8'd1, 2);

    // price 20: coins 2, 3, then cancel -> refund 5.
    begin_txn(8'd20);
    coin(3'd2, 2, 1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    coin(3'd3, 2, 1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    cancel = 1'b1;
    q.push_back('{is_done: 1'b0, total: 8'd5, chg: 8'd5, at: cyc + 2});
    step(1);
    cancel = 1'b0;
    step(3);

    // price 20: single coin 4 then idle -> timeout refund.
    begin_txn(8'd20);
    coin(3'd4, 1, 12, 1'b1, 1'b0, 8'd4, 8'd4, 9);

    // price 5, total 3: coin 2 with cancel -> payment wins.
    begin_txn(8'd5);
    coin(3'd2, 2, 1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    coin(3'd1, 2, 1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    chk("t6a_total3", {24'd0, paid_total}, 32'd3);
    cancel = 1'b1;
    coin(3'd2, 1, 3, 1'b1, 1'b1, 8'd5, 8'd0, 2);
    cancel = 1'b0;

    // price 9, total 3: coin 1 with cancel -> refund includes it.
    begin_txn(8'd9);
    coin(3'd2, 2, 1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    coin(3'd1, 2, 1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    cancel = 1'b1;
    paid = 3'd1;
    q.push_back('{is_done: 1'b0, total: 8'd4, chg: 8'd4, at: cyc + 2});
    step(1);
    cancel = 1'b0;
    paid = 3'd0;
    step(3);

    // start with price 0 is ignored.
    start = 1'b1;
    price = 8'd0;
    step(1);
    start = 1'b0;
    chk("zero_price_busy", {31'd0, busy}, 32'd0);
    coin(3'd5, 1, 2, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    chk("zero_price_total", {24'd0, paid_total}, 32'd4);

    // price 255: 36 sevens -> 252, next saturates at 255 with change 0.
    begin_txn(8'd255);
    for (int i = 0; i < 36; i++) coin(3'd7, 1, 1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    chk("sat_total252", {24'd0, paid_total}, 32'd252);
    coin(3'd7, 1, 3, 1'b1, 1'b1, 8'd255, 8'd0, 2);
    chk("sat_total_held", {24'd0, paid_total}, 32'd255);

    step(5);
    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
